// File: rtl/bash_csr_bank.sv
//------------------------------------------------------------------------------
// bash_csr_bank: CSR bank for the bash-hash core (X/L/Y/CMD/STATUS/CFG words).
// Optional feature macro: BASH_CSR_IRQ_EN (enables STATUS.irq_en and irq_o).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bash_csr_bank #(
  parameter int XLEN    = 32,
  parameter int NX      = 32,
  parameter int NY      = 16,
  parameter int ADDRLEN = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [XLEN/8-1:0]    we_i,
  input  logic [ADDRLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]      wrdata_i,
  output logic [XLEN-1:0]      rddata_o,
  output logic                 rdvalid_o,
  input  logic                 active_i,
  input  logic                 rdy_i,
  output logic                 prep_o,
  output logic                 start_o,
  output logic [XLEN-1:0]      l_reg_o,
  output logic [XLEN*NX-1:0]   x_reg_o,
  input  logic [XLEN*NY-1:0]   y_reg_i,
  output logic                 irq_o
);

  localparam int NB = XLEN / 8;
  localparam int C  = NX + NY;
  localparam logic [31:0]     CFG32 = {8'(NY), 8'(NX), 8'(XLEN), 8'h02};
  localparam logic [XLEN-1:0] CFGW  = XLEN'(CFG32);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [XLEN-1:0] x_q  [NX];
  logic [XLEN-1:0] ybuf [NY];
  logic [XLEN-1:0] l_q;
  logic            done, err, irq_en, rdy_q;

  logic [31:0]     widx;
  logic            wr, rd, locked, rdy_rise, err_set, st_wr, cmd_ok;
  logic            do_start, do_prep, done_n, err_n, irq_en_n;
  logic [XLEN-1:0] rd_mux;
  logic            unused_addr_bits;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] d,
                                            input logic [NB-1:0]   be);
    merge = old;
    for (int b = 0; b < NB; b++)
      if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  assign unused_addr_bits = ^addr_i[1:0];
  assign widx   = 32'(addr_i[ADDRLEN-1:2]);
  assign wr     = en_i & (|we_i);
  assign rd     = en_i & ~(|we_i);
  assign locked = (state == BUSY) | active_i;

  // Any write aimed at X, L or CMD while the core owns the state is an error.
  assign err_set  = wr & locked & ((widx < 32'(NX)) | (widx == 32'(C)) | (widx == 32'(C + 1)));
  assign cmd_ok   = wr & ~locked & (widx == 32'(C + 1)) & we_i[0];
  assign do_start = cmd_ok & wrdata_i[1];
  assign do_prep  = cmd_ok & wrdata_i[0];
  assign st_wr    = wr & (widx == 32'(C + 2)) & we_i[0];
  assign rdy_rise = rdy_i & ~rdy_q & (state == BUSY);

  // Set events are applied last so they win over a same-cycle clear.
  always_comb begin
    done_n = done;
    if (st_wr && wrdata_i[0]) done_n = 1'b0;
    if (do_start)             done_n = 1'b0;
    if (rdy_rise)             done_n = 1'b1;
    err_n = err;
    if (st_wr && wrdata_i[2]) err_n = 1'b0;
    if (err_set)              err_n = 1'b1;
`ifdef BASH_CSR_IRQ_EN
    irq_en_n = irq_en;
    if (st_wr) irq_en_n = wrdata_i[3];
`else
    irq_en_n = 1'b0;
`endif
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NX; i++)
      if (widx == 32'(i)) rd_mux = x_q[i];
    for (int i = 0; i < NY; i++)
      if (widx == 32'(NX + i)) rd_mux = ybuf[i];
    if (widx == 32'(C))     rd_mux = l_q;
    if (widx == 32'(C + 2)) rd_mux = XLEN'({state == BUSY, irq_en, err, active_i, done});
    if (widx == 32'(C + 3)) rd_mux = CFGW;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      l_q       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      irq_en    <= 1'b0;
      rdy_q     <= 1'b0;
      prep_o    <= 1'b0;
      start_o   <= 1'b0;
      rddata_o  <= '0;
      rdvalid_o <= 1'b0;
      irq_o     <= 1'b0;
      for (int i = 0; i < NX; i++) x_q[i]  <= '0;
      for (int i = 0; i < NY; i++) ybuf[i] <= '0;
    end else begin
      if (do_start)      state <= BUSY;
      else if (rdy_rise) state <= DONE;
      rdy_q <= rdy_i;
      if (rdy_rise)
        for (int i = 0; i < NY; i++) ybuf[i] <= y_reg_i[i*XLEN +: XLEN];
      if (wr && !locked) begin
        for (int i = 0; i < NX; i++)
          if (widx == 32'(i)) x_q[i] <= merge(x_q[i], wrdata_i, we_i);
        if (widx == 32'(C)) l_q <= merge(l_q, wrdata_i, we_i);
      end
      done      <= done_n;
      err       <= err_n;
      irq_en    <= irq_en_n;
      irq_o     <= done_n & irq_en_n;
      prep_o    <= do_prep;
      start_o   <= do_start;
      rdvalid_o <= rd;
      rddata_o  <= rd ? rd_mux : '0;
    end
  end

  generate
    for (genvar gi = 0; gi < NX; gi++) begin : g_xout
      assign x_reg_o[gi*XLEN +: XLEN] = x_q[gi];
    end
  endgenerate

  assign l_reg_o = l_q;

endmodule

`default_nettype wire

// File: tb/tb_bash_csr_bank.sv
//------------------------------------------------------------------------------
// tb_bash_csr_bank: directed table, hand sequences and random ops vs a model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bash_csr_bank;

  localparam int XLEN = 32;
  localparam int NX   = 32;
  localparam int NY   = 16;
  localparam int AL   = 8;
  localparam int C    = NX + NY;

  logic              clk, rst, en, active, rdy;
  logic [3:0]        we;
  logic [AL-1:0]     addr;
  logic [31:0]       wrdata;
  logic [31:0]       rddata, l_reg;
  logic              rdvalid, prep, start, irq;
  logic [XLEN*NX-1:0] x_reg;
  logic [XLEN*NY-1:0] y_reg;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [31:0] mx [NX];
  logic [31:0] my [NY];
  logic [31:0] ml;
  logic        mdone, merr, mirq_en, mbusy, mrdy_prev;
  logic [31:0] e_rd;
  logic        e_rv, e_prep, e_start, e_irq;

  bash_csr_bank #(.XLEN(XLEN), .NX(NX), .NY(NY), .ADDRLEN(AL)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr),
    .wrdata_i(wrdata), .rddata_o(rddata), .rdvalid_o(rdvalid),
    .active_i(active), .rdy_i(rdy), .prep_o(prep), .start_o(start),
    .l_reg_o(l_reg), .x_reg_o(x_reg), .y_reg_i(y_reg), .irq_o(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NX; i++) mx[i] = '0;
    for (int i = 0; i < NY; i++) my[i] = '0;
    ml = '0; mdone = 0; merr = 0; mirq_en = 0; mbusy = 0; mrdy_prev = 0;
    e_rd = '0; e_rv = 0; e_prep = 0; e_start = 0; e_irq = 0;
  endtask

  function automatic logic [31:0] model_read(input int w);
    if (w < NX)          return mx[w];
    else if (w < C)      return my[w - NX];
    else if (w == C)     return ml;
    else if (w == C + 2) return {27'd0, mbusy, mirq_en, merr, active, mdone};
    else if (w == C + 3) return 32'h1020_2002;
    return '0;
  endfunction

  // Predicts the state after one clock edge from the register-map rules.
  task automatic model_step(input logic e, input logic [3:0] be, input int w, input logic [31:0] d);
    logic locked, write, rise, set_err, clr_done, clr_err, busy0;
    busy0    = mbusy;
    locked   = mbusy || active;
    write    = e && (be != 0);
    rise     = rdy && !mrdy_prev;
    set_err  = 0; clr_done = 0; clr_err = 0;
    e_rv     = e && (be == 0);
    e_rd     = e_rv ? model_read(w) : 32'd0;
    e_prep   = 0; e_start = 0;
    if (write) begin
      if (w < NX || w == C || w == C + 1) begin
        if (locked) set_err = 1;
        else begin
          for (int b = 0; b < 4; b++)
            if (be[b]) begin
              if (w < NX) mx[w][8*b +: 8] = d[8*b +: 8];
              if (w == C) ml[8*b +: 8]    = d[8*b +: 8];
            end
          if (w == C + 1 && be[0]) begin
            e_prep = d[0]; e_start = d[1];
          end
        end
      end
      if (w == C + 2 && be[0]) begin
        clr_done = d[0];
        clr_err  = d[2];
`ifdef BASH_CSR_IRQ_EN
        mirq_en = d[3];
`endif
      end
    end
    if (clr_done || e_start) mdone = 0;
    if (clr_err) merr = 0;
    if (set_err) merr = 1;
    if (e_start) mbusy = 1;
    if (rise && busy0) begin
      for (int i = 0; i < NY; i++) my[i] = y_reg[i*32 +: 32];
      mdone = 1;
      mbusy = 0;
    end
    mrdy_prev = rdy;
    e_irq = mdone & mirq_en;
  endtask

  // Applies one bus cycle, advances the model and compares every output.
  task automatic op(input logic e, input logic [3:0] be, input int w, input logic [31:0] d);
    logic [XLEN*NX-1:0] ex;
    en = e; we = be; addr = AL'(w * 4 + $urandom_range(0, 3)); wrdata = d;
    if (rst) model_reset();
    else     model_step(e, be, w, d);
    @(posedge clk);
    #1;
    en = 0; we = 0;
    chk("rddata", rddata, e_rd);
    chk("rdvalid", 32'(rdvalid), 32'(e_rv));
    chk("prep", 32'(prep), 32'(e_prep));
    chk("start", 32'(start), 32'(e_start));
    chk("irq", 32'(irq), 32'(e_irq));
    chk("l_reg", l_reg, ml);
    for (int i = 0; i < NX; i++) ex[i*32 +: 32] = mx[i];
    tests++;
    if (x_reg !== ex) begin
      fails++;
      for (int i = 0; i < NX; i++)
        if (x_reg[i*32 +: 32] !== ex[i*32 +: 32]) begin
          $display("FAIL x_reg word %0d: got %h expected %h", i, x_reg[i*32 +: 32], ex[i*32 +: 32]);
          break;
        end
    end
  endtask

  task automatic randomize_y();
    for (int i = 0; i < NY; i++) y_reg[i*32 +: 32] = $urandom;
  endtask

  typedef struct {
    logic [3:0]  be;
    int          w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{4'hF, 3,     32'hAABBCCDD, 32'h0};
    tbl[1] = '{4'h5, 3,     32'h11223344, 32'h0};
    tbl[2] = '{4'h0, 3,     32'h0,        32'hAA22CC44};
    tbl[3] = '{4'h0, C + 3, 32'h0,        32'h1020_2002};
    tbl[4] = '{4'hF, C,     32'hCAFEF00D, 32'h0};
    tbl[5] = '{4'h0, C,     32'h0,        32'hCAFEF00D};
    tbl[6] = '{4'hF, C + 1, 32'h0,        32'h0};
    tbl[7] = '{4'h0, C + 1, 32'h0,        32'h0};
    tbl[8] = '{4'hF, C + 4, 32'hFFFFFFFF, 32'h0};
    tbl[9] = '{4'h0, C + 4, 32'h0,        32'h0};

    rst = 1; en = 0; we = 0; addr = '0; wrdata = '0; active = 0; rdy = 0;
    y_reg = '0;
    model_reset();
    op(0, 0, 0, 0);
    op(0, 0, 0, 0);
    rst = 0;
    chk("reset_rdvalid", 32'(rdvalid), 32'd0);
    chk("reset_x_reg0", x_reg[31:0], 32'd0);
    op(1, 0, C + 2, 0);
    chk("reset_status", rddata, 32'd0);

    for (int i = 0; i < 10; i++) begin
      op(1, tbl[i].be, tbl[i].w, tbl[i].d);
      if (tbl[i].be == 0) begin
        chk($sformatf("tbl%0d_rd", i), rddata, tbl[i].exp);
        chk($sformatf("tbl%0d_rv", i), 32'(rdvalid), 32'd1);
      end
    end
    op(0, 0, 0, 0);
    chk("idle_rdvalid", 32'(rdvalid), 32'd0);

    // Start / done with stable Y capture
    op(1, 4'hF, C + 1, 32'd2);
    chk("start_pulse", 32'(start), 32'd1);
    op(0, 0, 0, 0);
    chk("start_once", 32'(start), 32'd0);
    op(1, 0, C + 2, 0);
    chk("busy_bit", rddata & 32'h10, 32'h10);
    randomize_y();
    y_reg[31:0] = 32'h12345678;
    rdy = 1;
    op(0, 0, 0, 0);
    randomize_y();
    op(1, 0, NX, 0);
    chk("y0_capture", rddata, 32'h12345678);
    op(1, 0, C + 2, 0);
    chk("done_bit", rddata & 32'h11, 32'h01);
    rdy = 0;
    op(0, 0, 0, 0);

    // Protection while busy
    op(1, 4'hF, C + 1, 32'd2);
    op(1, 4'hF, 0, 32'hFFFFFFFF);
    chk("prot_x0", x_reg[31:0], 32'd0);
    op(1, 4'hF, C + 1, 32'd3);
    chk("prot_prep", 32'(prep), 32'd0);
    chk("prot_start", 32'(start), 32'd0);
    op(1, 0, C + 2, 0);
    chk("err_set", rddata & 32'h4, 32'h4);
    op(1, 4'hF, C + 2, 32'd4);
    op(1, 0, C + 2, 0);
    chk("err_clr", rddata & 32'h4, 32'h0);

    // Done set and done W1C on the same edge
    rdy = 1;
    op(1, 4'hF, C + 2, 32'd1);
    op(1, 0, C + 2, 0);
    chk("race_done", rddata & 32'h1, 32'h1);
    rdy = 0;

    // Interrupt
    op(1, 4'hF, C + 2, 32'd8);
    op(1, 4'hF, C + 1, 32'd2);
    rdy = 1;
    op(0, 0, 0, 0);
    rdy = 0;
`ifdef BASH_CSR_IRQ_EN
    chk("irq_on", 32'(irq), 32'd1);
`else
    chk("irq_off", 32'(irq), 32'd0);
    op(1, 0, C + 2, 0);
    chk("irq_en_absent", rddata & 32'h8, 32'h0);
`endif
    op(1, 4'hF, C + 2, 32'd1);
    chk("irq_clr", 32'(irq), 32'd0);

    // Reset in the middle of a run
    op(1, 4'hF, 5, 32'h55AA55AA);
    op(1, 4'hF, C, 32'h0BADBEEF);
    op(1, 4'hF, C + 1, 32'd2);
    rst = 1;
    op(1, 4'hF, C + 1, 32'd3);
    rst = 0;
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_l", l_reg, 32'd0);
    op(1, 0, 5, 0);
    chk("rst_x5", rddata, 32'd0);
    op(1, 0, NX, 0);
    chk("rst_y0", rddata, 32'd0);
    op(1, 0, C + 2, 0);
    chk("rst_status", rddata, 32'd0);
    op(1, 0, C + 3, 0);
    chk("rst_cfg", rddata, 32'h1020_2002);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      int          w;
      logic [3:0]  be;
      logic [31:0] d;
      active = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) rdy = ~rdy;
      randomize_y();
      rst = ($urandom_range(0, 399) == 0);
      w = $urandom_range(0, C + 5);
      case ($urandom_range(0, 3))
        0, 3:    be = 4'h0;
        1:       be = 4'hF;
        default: be = 4'($urandom);
      endcase
      d = $urandom;
      if ((w == C + 1 || w == C + 2) && $urandom_range(0, 1) == 1) d = d & 32'hF;
      op($urandom_range(0, 2) != 0, be, w, d);
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
